// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   Converts a simple valid/ready request/response pair from the core into
//   single APB transfers (SETUP -> ACCESS), one transfer at a time.
//
//   Optional build macro: APB_MASTER_TIMEOUT_EN
//     When defined, an ACCESS phase that sees no pready for TIMEOUT_CYCLES
//     cycles is aborted and answered with resp_err=1, resp_rdata=0.
//     When undefined, ACCESS waits for pready indefinitely.
//
//   Ports
//     clock, reset           : clock, asynchronous active-high reset
//     req_valid/req_ready    : request handshake (ready only in IDLE)
//     req_addr/write/wdata/wstrb : request payload, latched on acceptance
//     resp_valid/resp_ready  : response handshake
//     resp_rdata, resp_err   : read data (0 for writes), slave error/timeout
//     out_p*                 : APB initiator side
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request, req_ready=1
//   SETUP  | psel=1, penable=0 for one cycle
//   ACCESS | psel=1, penable=1, waiting for pready (or timeout)
//   RESP   | resp_valid=1, waiting for resp_ready
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
    // Down-counter over ACCESS cycles; terminal count 0 marks the last one.
    logic [TO_W-1:0] to_cnt;
`endif

    // Combinational so that it is 0 while reset is held and 1 in the very
    // first cycle after release.
    assign req_ready = (state == IDLE) && !reset;
    assign out_pprot = 3'b000;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
            out_paddr   <= 32'h0;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_pwrite  <= 1'b0;
            out_pwdata  <= 32'h0;
            out_pstrb   <= 4'h0;
`ifdef APB_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // The APB output registers double as the request latch.
                        out_psel   <= 1'b1;
                        out_paddr  <= req_addr;
                        out_pwrite <= req_write;
                        out_pwdata <= req_wdata;
                        out_pstrb  <= req_write ? req_wstrb : 4'h0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    out_penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    to_cnt      <= TO_LOAD;
`endif
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (out_pready) begin
                        resp_valid  <= 1'b1;
                        resp_rdata  <= out_pwrite ? 32'h0 : out_prdata;
                        resp_err    <= out_pslverr;
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        out_paddr   <= 32'h0;
                        out_pwrite  <= 1'b0;
                        out_pwdata  <= 32'h0;
                        out_pstrb   <= 4'h0;
                        state       <= RESP;
`ifdef APB_MASTER_TIMEOUT_EN
                    end else if (to_cnt == '0) begin
                        resp_valid  <= 1'b1;
                        resp_rdata  <= 32'h0;
                        resp_err    <= 1'b1;
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        out_paddr   <= 32'h0;
                        out_pwrite  <= 1'b0;
                        out_pwdata  <= 32'h0;
                        out_pstrb   <= 4'h0;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .out_paddr   (out_paddr),
        .out_psel    (out_psel),
        .out_penable (out_penable),
        .out_pprot   (out_pprot),
        .out_pwrite  (out_pwrite),
        .out_pwdata  (out_pwdata),
        .out_pstrb   (out_pstrb),
        .out_pready  (out_pready),
        .out_prdata  (out_prdata),
        .out_pslverr (out_pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Presents a request at the current negedge, crosses edge 0, and
    // returns at the negedge of cycle 1 with req_valid dropped.
    task automatic send(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        req_valid = 1'b1;
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        req_write   = 1'b0;
        req_wdata   = 32'h0;
        req_wstrb   = 4'h0;
        resp_ready  = 1'b0;
        out_pready  = 1'b0;
        out_prdata  = 32'h0;
        out_pslverr = 1'b0;

        // ---- reset state
        step(); step();
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_psel",      {31'h0, out_psel}, 32'h0);
        check("rst_resp_valid",{31'h0, resp_valid}, 32'h0);
        check("rst_paddr",     out_paddr, 32'h0);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        step();

        // ---- write, pready tied high, minimum latency
        out_pready = 1'b1;
        out_prdata = 32'hDEAD_BEEF;
        send(32'h1000_2000, 1'b1, 32'h0000_A5A5, 4'hF);
        check("wr_c1_psel",    {31'h0, out_psel}, 32'h1);
        check("wr_c1_penable", {31'h0, out_penable}, 32'h0);
        check("wr_c1_paddr",   out_paddr, 32'h1000_2000);
        check("wr_c1_pwrite",  {31'h0, out_pwrite}, 32'h1);
        check("wr_c1_pwdata",  out_pwdata, 32'h0000_A5A5);
        check("wr_c1_pstrb",   {28'h0, out_pstrb}, 32'hF);
        check("wr_c1_pprot",   {29'h0, out_pprot}, 32'h0);
        check("wr_c1_req_ready", {31'h0, req_ready}, 32'h0);
        step();
        check("wr_c2_psel",    {31'h0, out_psel}, 32'h1);
        check("wr_c2_penable", {31'h0, out_penable}, 32'h1);
        check("wr_c2_resp_valid", {31'h0, resp_valid}, 32'h0);
        step();
        check("wr_c3_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("wr_c3_resp_err",   {31'h0, resp_err}, 32'h0);
        check("wr_c3_resp_rdata", resp_rdata, 32'h0);
        check("wr_c3_psel",       {31'h0, out_psel}, 32'h0);
        check("wr_c3_paddr",      out_paddr, 32'h0);
        check("wr_c3_pwdata",     out_pwdata, 32'h0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("wr_c4_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("wr_c4_req_ready",  {31'h0, req_ready}, 32'h1);

        // ---- read, pready low for 3 ACCESS cycles, then response stall
        out_pready = 1'b0;
        out_prdata = 32'h0000_1234;
        send(32'h1000_2004, 1'b0, 32'h0000_FFFF, 4'hF);
        check("rd_c1_pstrb",  {28'h0, out_pstrb}, 32'h0);
        check("rd_c1_pwrite", {31'h0, out_pwrite}, 32'h0);
        check("rd_c1_paddr",  out_paddr, 32'h1000_2004);
        for (int c = 2; c <= 4; c++) begin
            step();
            check("rd_wait_penable", {31'h0, out_penable}, 32'h1);
            check("rd_wait_paddr",   out_paddr, 32'h1000_2004);
            check("rd_wait_resp_valid", {31'h0, resp_valid}, 32'h0);
        end
        step();
        out_pready = 1'b1;
        check("rd_c5_resp_valid", {31'h0, resp_valid}, 32'h0);
        step();
        out_pready = 1'b1;
        out_prdata = 32'hCAFE_0000;
        check("rd_c6_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("rd_c6_resp_rdata", resp_rdata, 32'h0000_1234);
        check("rd_c6_resp_err",   {31'h0, resp_err}, 32'h0);
        req_valid = 1'b1;
        req_addr  = 32'h2000_0000;
        req_write = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_resp_valid", {31'h0, resp_valid}, 32'h1);
            check("stall_resp_rdata", resp_rdata, 32'h0000_1234);
            check("stall_req_ready",  {31'h0, req_ready}, 32'h0);
            check("stall_psel",       {31'h0, out_psel}, 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("stall_end_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("stall_end_req_ready",  {31'h0, req_ready}, 32'h1);
        step();
        check("stall_end_psel", {31'h0, out_psel}, 32'h0);

        // ---- write with slave error
        out_pready  = 1'b1;
        out_pslverr = 1'b1;
        send(32'h1000_3000, 1'b1, 32'h1111_2222, 4'h3);
        check("err_c1_pstrb", {28'h0, out_pstrb}, 32'h3);
        step();
        step();
        out_pslverr = 1'b0;
        check("err_c3_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("err_c3_resp_err",   {31'h0, resp_err}, 32'h1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("err_c4_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("err_c4_req_ready",  {31'h0, req_ready}, 32'h1);
        check("err_c4_resp_err",   {31'h0, resp_err}, 32'h0);

        // ---- pready stuck low
        out_pready = 1'b0;
        out_prdata = 32'h5555_AAAA;
        send(32'h1000_4000, 1'b0, 32'h0, 4'h0);
        for (int c = 2; c <= 5; c++) begin
            step();
            check("stuck_access_psel", {31'h0, out_psel}, 32'h1);
        end
`ifdef APB_MASTER_TIMEOUT_EN
        step();
        check("to_psel",       {31'h0, out_psel}, 32'h0);
        check("to_penable",    {31'h0, out_penable}, 32'h0);
        check("to_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("to_resp_err",   {31'h0, resp_err}, 32'h1);
        check("to_resp_rdata", resp_rdata, 32'h0);
`else
        for (int c = 0; c < 20; c++) begin
            step();
            check("noto_psel",       {31'h0, out_psel}, 32'h1);
            check("noto_resp_valid", {31'h0, resp_valid}, 32'h0);
        end
        out_pready = 1'b1;
        step();
        out_pready = 1'b0;
        check("noto_resp_valid_end", {31'h0, resp_valid}, 32'h1);
        check("noto_resp_rdata",     resp_rdata, 32'h5555_AAAA);
`endif
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("stuck_end_req_ready", {31'h0, req_ready}, 32'h1);

        // ---- reset asserted mid-ACCESS, between edges
        out_pready = 1'b0;
        send(32'h1000_5000, 1'b1, 32'h0000_0077, 4'hF);
        step();
        check("mid_pre_penable", {31'h0, out_penable}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_psel",       {31'h0, out_psel}, 32'h0);
        check("mid_penable",    {31'h0, out_penable}, 32'h0);
        check("mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("mid_paddr",      out_paddr, 32'h0);
        check("mid_req_ready",  {31'h0, req_ready}, 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("mid_post_req_ready", {31'h0, req_ready}, 32'h1);
        check("mid_post_psel",      {31'h0, out_psel}, 32'h0);
        step();
        out_pready = 1'b1;
        send(32'h1000_6000, 1'b1, 32'h0000_0001, 4'h1);
        step();
        step();
        check("mid_after_resp_valid", {31'h0, resp_valid}, 32'h1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
